// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle for the unified memory arbiter: fetch port, load/store port and memory port.
// The master modport is the arbiter's view; slave is the surrounding core/memory view.
interface unified_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [31:0]           if_rdata_o;

  logic                  ls_req_i;
  logic                  ls_we_i;
  logic                  ls_byte_i;
  logic [ADDR_WIDTH-1:0] ls_addr_i;
  logic [31:0]           ls_wdata_i;
  logic                  ls_gnt_o;
  logic                  ls_rvalid_o;
  logic [31:0]           ls_rdata_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [3:0]            mem_be_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_wdata_o;
  logic [31:0]           mem_rdata_i;

  modport master (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_we_i, ls_byte_i, ls_addr_i, ls_wdata_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport slave (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_we_i, ls_byte_i, ls_addr_i, ls_wdata_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-outstanding arbiter sharing a fixed-latency memory between fetch and load/store,
// with load/store priority, bounded fetch starvation and byte-lane steering.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  unified_mem_arbiter_if.master  bus
);
  localparam int CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  owner_ls_q, byte_q, we_q;
  logic [1:0]            off_q;
  logic                  ret, slot, starved, gnt_ls, gnt_if;

  function automatic logic [3:0] lane_be(input logic is_byte, input logic [1:0] off);
    return is_byte ? (4'b0001 << off) : 4'b1111;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off);
    return {24'b0, word[8*off +: 8]};
  endfunction

  always_comb begin
    ret     = (state_q == WAIT) && (cnt_q == CNT_W'(MEM_LATENCY));
    slot    = (state_q == IDLE) || ret;
    starved = bus.if_req_i && (starve_q == STARVE_W'(STARVE_LIMIT));
    gnt_ls  = slot && bus.ls_req_i && !starved;
    gnt_if  = slot && bus.if_req_i && !gnt_ls;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  // Transaction attributes only matter while WAIT, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (gnt_ls || gnt_if) begin
      owner_ls_q <= gnt_ls;
      byte_q     <= gnt_ls && bus.ls_byte_i;
      we_q       <= gnt_ls && bus.ls_we_i;
      off_q      <= bus.ls_addr_i[1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;

    if (slot) begin
      if (gnt_ls || gnt_if) begin
        state_d = WAIT;
        cnt_d   = CNT_W'(1);
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (!bus.if_req_i || gnt_if)
      starve_d = '0;
    else if (gnt_ls && (starve_q != STARVE_W'(STARVE_LIMIT)))
      starve_d = starve_q + STARVE_W'(1);

    bus.if_gnt_o    = gnt_if;
    bus.ls_gnt_o    = gnt_ls;
    bus.mem_req_o   = gnt_if || gnt_ls;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = 4'b0000;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (gnt_ls) begin
      bus.mem_we_o    = bus.ls_we_i;
      bus.mem_be_o    = lane_be(bus.ls_byte_i, bus.ls_addr_i[1:0]);
      bus.mem_addr_o  = {bus.ls_addr_i[ADDR_WIDTH-1:2], 2'b00};
      bus.mem_wdata_o = bus.ls_byte_i ? {4{bus.ls_wdata_i[7:0]}} : bus.ls_wdata_i;
    end else if (gnt_if) begin
      bus.mem_be_o    = 4'b1111;
      bus.mem_addr_o  = {bus.if_addr_i[ADDR_WIDTH-1:2], 2'b00};
    end

    bus.if_rvalid_o = ret && !owner_ls_q;
    bus.ls_rvalid_o = ret && owner_ls_q;
    bus.if_rdata_o  = '0;
    bus.ls_rdata_o  = '0;
    if (bus.if_rvalid_o)
      bus.if_rdata_o = bus.mem_rdata_i;
    if (bus.ls_rvalid_o && !we_q)
      bus.ls_rdata_o = byte_q ? lane_extract(bus.mem_rdata_i, off_q) : bus.mem_rdata_i;
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: vector table for single transactions,
// scoreboard of pending responses, hand sequences for overlap, starvation and reset.
module tb_unified_mem_arbiter;
  localparam int LAT = 2;

  logic clk;
  logic rst_ni;
  int   cyc;
  int   n_tests;
  int   n_fail;

  unified_mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  unified_mem_arbiter #(
    .ADDR_WIDTH  (32),
    .MEM_LATENCY (LAT),
    .STARVE_LIMIT(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  typedef struct {
    bit          ls;
    bit          we;
    bit          byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    bit          ls;
    logic [31:0] rd;
    int          cyc;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Response monitor: every rvalid must match the oldest pending grant.
  always @(negedge clk) begin
    sb_t e;
    if (rst_ni && (bus.if_rvalid_o || bus.ls_rvalid_o)) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_rvalid");
      end else begin
        e = sb.pop_front();
        check("rvalid_owner", {bus.if_rvalid_o, bus.ls_rvalid_o}, e.ls ? 2'b01 : 2'b10);
        check("rdata", e.ls ? bus.ls_rdata_o : bus.if_rdata_o, e.rd);
        check("latency", cyc - e.cyc, LAT);
      end
    end
  end

  task automatic idle_inputs();
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = '0;
    bus.ls_req_i   = 1'b0;
    bus.ls_we_i    = 1'b0;
    bus.ls_byte_i  = 1'b0;
    bus.ls_addr_i  = '0;
    bus.ls_wdata_i = '0;
  endtask

  task automatic wait_grant(output int gcyc, output bit ok);
    ok   = 1'b0;
    gcyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.if_gnt_o || bus.ls_gnt_o) begin
        ok   = 1'b1;
        gcyc = cyc;
        break;
      end
    end
    if (!ok) fail_now("grant_timeout");
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_now("rvalid_timeout");
  endtask

  task automatic push_sb(input bit ls, input logic [31:0] rd, input int gc);
    sb_t e;
    e.ls  = ls;
    e.rd  = rd;
    e.cyc = gc;
    sb.push_back(e);
  endtask

  function automatic vec_t mk(input bit ls, input bit we, input bit byt, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] mrd, input logic [3:0] be,
                              input logic [31:0] maddr, input logic [31:0] mwd, input logic [31:0] rd);
    vec_t v;
    v.ls = ls; v.we = we; v.byt = byt; v.addr = addr; v.wdata = wdata; v.mrd = mrd;
    v.be = be; v.maddr = maddr; v.mwd = mwd; v.rd = rd;
    return v;
  endfunction

  initial begin
    int  gc;
    int  prev;
    bit  ok;
    bit  exp_ls[10];
    vec_t v;

    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;

    //               ls we byt addr          wdata         mrd           be       maddr         mwd           rd
    vecs.push_back(mk(0, 0, 0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 4'b1111, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF));
    vecs.push_back(mk(1, 1, 1, 32'h0000_0203, 32'h0000_00A5, 32'h0,        4'b1000, 32'h0000_0200, 32'hA5A5_A5A5, 32'h0));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0202, 32'h0,        32'h1122_3344, 4'b0100, 32'h0000_0200, 32'h0,        32'h0000_0022));
    vecs.push_back(mk(1, 0, 0, 32'h0000_0202, 32'h0,        32'h1122_3344, 4'b1111, 32'h0000_0200, 32'h0,        32'h1122_3344));
    vecs.push_back(mk(1, 1, 0, 32'h0000_0304, 32'h1234_5678, 32'hCAFE_F00D, 4'b1111, 32'h0000_0304, 32'h1234_5678, 32'h0));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0201, 32'h0,        32'h1122_3344, 4'b0010, 32'h0000_0200, 32'h0,        32'h0000_0033));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0200, 32'h0,        32'h8899_AABB, 4'b0001, 32'h0000_0200, 32'h0,        32'h0000_00BB));
    vecs.push_back(mk(1, 1, 1, 32'h0000_0200, 32'hFFFF_FF3C, 32'h0,        4'b0001, 32'h0000_0200, 32'h3C3C_3C3C, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0000_1007, 32'h0,        32'h0102_0304, 4'b1111, 32'h0000_1004, 32'h0,        32'h0102_0304));
    vecs.push_back(mk(1, 0, 1, 32'h0000_03FF, 32'h0,        32'h80FF_7F01, 4'b1000, 32'h0000_03FC, 32'h0,        32'h0000_0080));

    // Reset and idle
    idle_inputs();
    bus.mem_rdata_i = 32'hFFFF_FFFF;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ctrl", {bus.if_gnt_o, bus.if_rvalid_o, bus.ls_gnt_o, bus.ls_rvalid_o,
                          bus.mem_req_o, bus.mem_we_o, bus.mem_be_o}, 0);
      check("idle_data", {bus.if_rdata_o | bus.ls_rdata_o, bus.mem_addr_o | bus.mem_wdata_o}, 0);
    end

    // Vector table: one transaction at a time
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge clk); #1;
      bus.mem_rdata_i = v.mrd;
      if (v.ls) begin
        bus.ls_req_i   = 1'b1;
        bus.ls_we_i    = v.we;
        bus.ls_byte_i  = v.byt;
        bus.ls_addr_i  = v.addr;
        bus.ls_wdata_i = v.wdata;
      end else begin
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = v.addr;
      end
      wait_grant(gc, ok);
      if (ok) begin
        check("gnt_owner", {bus.if_gnt_o, bus.ls_gnt_o}, v.ls ? 2'b01 : 2'b10);
        check("mem_ctrl", {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o}, {1'b1, v.we, v.be});
        check("mem_addr", bus.mem_addr_o, v.maddr);
        check("mem_wdata", bus.mem_wdata_o, v.mwd);
        push_sb(v.ls, v.rd, gc);
      end
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("wait_quiet", {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.if_gnt_o, bus.ls_gnt_o,
                           |bus.mem_addr_o, |bus.mem_wdata_o}, 0);
      drain();
    end

    // Request arriving mid-WAIT is held off until the return slot
    @(posedge clk); #1;
    bus.mem_rdata_i = 32'h0BAD_F00D;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0100;
    wait_grant(gc, ok);
    if (ok) push_sb(1'b0, 32'h0BAD_F00D, gc);
    @(posedge clk); #1;
    bus.if_req_i  = 1'b0;
    bus.ls_req_i  = 1'b1;
    bus.ls_addr_i = 32'h0000_0500;
    @(negedge clk);
    check("no_gnt_in_wait", {bus.ls_gnt_o, bus.mem_req_o}, 0);
    prev = gc;
    wait_grant(gc, ok);
    if (ok) begin
      check("slot_gnt_cycle", gc - prev, LAT);
      push_sb(1'b1, 32'h0BAD_F00D, gc);
    end
    @(posedge clk); #1;
    idle_inputs();
    drain();

    // Starvation bound: LS x4 then IF, repeating
    exp_ls = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    @(posedge clk); #1;
    bus.mem_rdata_i = 32'h55AA_33CC;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0800;
    bus.ls_req_i  = 1'b1;
    bus.ls_addr_i = 32'h0000_0400;
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      wait_grant(gc, ok);
      if (!ok) break;
      check("starve_order", {bus.if_gnt_o, bus.ls_gnt_o}, exp_ls[i] ? 2'b01 : 2'b10);
      if (i > 0) check("starve_spacing", gc - prev, LAT);
      prev = gc;
      push_sb(bus.ls_gnt_o, 32'h55AA_33CC, gc);
    end
    @(posedge clk); #1;
    idle_inputs();
    drain();

    // Reset during an outstanding load drops it
    @(posedge clk); #1;
    bus.mem_rdata_i = 32'h1122_3344;
    bus.ls_req_i  = 1'b1;
    bus.ls_byte_i = 1'b1;
    bus.ls_addr_i = 32'h0000_0202;
    wait_grant(gc, ok);
    @(posedge clk); #1;
    idle_inputs();
    rst_ni = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_drop", {bus.if_rvalid_o, bus.ls_rvalid_o, bus.mem_req_o}, 0);
    end
    #1 rst_ni = 1'b1;
    @(posedge clk); #1;
    bus.mem_rdata_i = 32'h7777_0001;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0040;
    prev = cyc;
    wait_grant(gc, ok);
    if (ok) begin
      check("post_reset_gnt", {gc - prev, 30'b0, bus.if_gnt_o, bus.mem_req_o}, {32'd0, 32'd3});
      push_sb(1'b0, 32'h7777_0001, gc);
    end
    @(posedge clk); #1;
    idle_inputs();
    drain();

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
